// File: rtl/adaptation_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : adaptation_scheduler_pkg
// Desc   : Phase encodings and sizing helpers shared by the adaptation scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
package adaptation_scheduler_pkg;

  typedef enum logic [2:0] {
    PH_STARTUP = 3'd0,
    PH_CMA     = 3'd1,
    PH_LMS     = 3'd2,
    PH_HOLD    = 3'd3,
    PH_IDLE    = 3'd4
  } phase_t;

  localparam int c_nb_cnt = 32;

  function automatic int gear_width(input int n_gears);
    return (n_gears > 1) ? $clog2(n_gears) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adaptation_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : adaptation_scheduler_if
// Desc   : Valid/ready coefficient write port between scheduler and memory.
// Rev    : 1.0 - initial release
// ============================================================================
interface adaptation_scheduler_if #(
  parameter int FFE_LEN = 21,
  parameter int NB      = 8
);
  logic [FFE_LEN*NB-1:0] new_coeff;
  logic                  wr_valid;
  logic                  wr_ready;

  modport master (output new_coeff, output wr_valid, input wr_ready);
  modport slave  (input new_coeff, input wr_valid, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/adaptation_scheduler_mu_gear.sv
`default_nettype none
// ============================================================================
// Module : adaptation_scheduler_mu_gear
// Desc   : LMS gear counter, mu gear shift and divergence run detector.
// Rev    : 1.0 - initial release
// ============================================================================
module adaptation_scheduler_mu_gear
  import adaptation_scheduler_pkg::*;
#(
  parameter  int NB_MU   = 16,
  parameter  int NB_CNT  = c_nb_cnt,
  parameter  int N_GEARS = 4,
  localparam int GEAR_W  = gear_width(N_GEARS)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_clear,
  input  wire logic              i_lms_adv,
  input  wire logic              i_lms_phase,
  input  wire logic              i_wr_accept,
  input  wire logic [NB_CNT-1:0] i_gear_period,
  input  wire logic [15:0]       i_div_limit,
  input  wire logic              i_err_flag,
  input  wire logic [NB_MU-1:0]  i_mu_lms,
  output logic [GEAR_W-1:0]      o_gear,
  output logic [NB_MU-1:0]       o_mu_lms,
  output logic                   o_diverged
);

  localparam logic [GEAR_W-1:0] c_GEAR_MAX = GEAR_W'(N_GEARS - 1);

  logic [NB_CNT-1:0]       r_gear_cnt;
  logic [GEAR_W-1:0]       r_gear;
  logic [15:0]             r_err_run;
  logic                    w_gear_step;
  logic signed [NB_MU-1:0] w_mu_shift;

  assign o_diverged  = i_lms_adv && i_err_flag && (i_div_limit != 16'd0) &&
                       (({1'b0, r_err_run} + 17'd1) >= {1'b0, i_div_limit});
  assign w_gear_step = ({1'b0, r_gear_cnt} + (NB_CNT+1)'(1)) >= {1'b0, i_gear_period};

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || o_diverged) begin
      r_gear_cnt <= '0;
      r_gear     <= '0;
      r_err_run  <= '0;
    end else if (i_lms_adv) begin
      if (i_wr_accept && (i_gear_period != '0)) begin
        if (w_gear_step) begin
          r_gear_cnt <= '0;
          if (r_gear != c_GEAR_MAX) r_gear <= r_gear + GEAR_W'(1);
        end else begin
          r_gear_cnt <= r_gear_cnt + NB_CNT'(1);
        end
      end
      if (!i_err_flag)               r_err_run <= '0;
      else if (r_err_run != 16'hFFFF) r_err_run <= r_err_run + 16'd1;
    end
  end

  // Kept as a separate signed net so the shift stays arithmetic.
  assign w_mu_shift = $signed(i_mu_lms) >>> r_gear;
  assign o_mu_lms   = i_lms_phase ? w_mu_shift : '0;
  assign o_gear     = r_gear;

endmodule
`default_nettype wire

// File: rtl/adaptation_scheduler.sv
`default_nettype none
// ============================================================================
// Module : adaptation_scheduler
// Desc   : FFE adaptation control: STARTUP/CMA/LMS timeline, decimated commits.
// Rev    : 1.0 - initial release
// ============================================================================
module adaptation_scheduler
  import adaptation_scheduler_pkg::*;
#(
  parameter  int FFE_LEN = 21,
  parameter  int NB      = 8,
  parameter  int NB_MU   = 16,
  parameter  int NB_CNT  = c_nb_cnt,
  parameter  int N_GEARS = 4,
  localparam int GEAR_W  = gear_width(N_GEARS)
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  enable,
  input  wire logic                  i_restart,
  input  wire logic                  i_freeze,
  input  wire logic [NB_CNT-1:0]     i_startup_delay,
  input  wire logic [NB_CNT-1:0]     i_cma_duration,
  input  wire logic [7:0]            i_update_div,
  input  wire logic [NB_CNT-1:0]     i_gear_period,
  input  wire logic [15:0]           i_div_limit,
  input  wire logic                  i_err_flag,
  input  wire logic [NB_MU-1:0]      i_mu_cma,
  input  wire logic [NB_MU-1:0]      i_mu_lms,
  input  wire logic [FFE_LEN*NB-1:0] i_coeff_flat,
  input  wire logic [FFE_LEN*NB-1:0] i_cma_coeff,
  input  wire logic [FFE_LEN*NB-1:0] i_lms_coeff,
  adaptation_scheduler_if.master     wr,
  output logic [NB_MU-1:0]           o_mu_cma,
  output logic [NB_MU-1:0]           o_mu_lms,
  output logic [2:0]                 o_phase,
  output logic [GEAR_W-1:0]          o_gear,
  output logic [NB_CNT-1:0]          o_iteration_count,
  output logic [7:0]                 o_fallback_count
);

  phase_t                  r_phase, r_saved;
  logic [NB_CNT-1:0]       r_cnt, r_iter;
  logic [7:0]              r_div, r_fb;
  logic                    r_wr_valid;
  logic [FFE_LEN*NB-1:0]   r_new_coeff;

  phase_t                  w_phase_nxt, w_saved_nxt;
  logic [NB_CNT-1:0]       w_cnt_nxt, w_iter_nxt, w_len;
  logic [7:0]              w_div_nxt, w_fb_nxt;
  logic                    w_valid_nxt;
  logic [FFE_LEN*NB-1:0]   w_data_nxt;
  logic                    w_adv, w_accept, w_cnt_done, w_running, w_strobe, w_to_lms;
  logic                    w_lms_adv, w_diverged;

  // Current coefficients are observed only as a debug tap.
  logic w_unused_coeff;
  assign w_unused_coeff = ^i_coeff_flat;

  assign w_adv      = enable && !i_freeze;
  assign w_accept   = r_wr_valid && wr.wr_ready;
  assign w_len      = (r_phase == PH_STARTUP) ? i_startup_delay : i_cma_duration;
  assign w_cnt_done = ({1'b0, r_cnt} + (NB_CNT+1)'(1)) >= {1'b0, w_len};
  assign w_running  = (r_phase == PH_STARTUP) || (r_phase == PH_CMA) || (r_phase == PH_LMS);
  assign w_lms_adv  = (r_phase == PH_LMS) && w_adv;

  adaptation_scheduler_mu_gear #(
    .NB_MU   (NB_MU),
    .NB_CNT  (NB_CNT),
    .N_GEARS (N_GEARS)
  ) u_mu_gear (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (i_restart || w_to_lms),
    .i_lms_adv     (w_lms_adv),
    .i_lms_phase   (r_phase == PH_LMS),
    .i_wr_accept   (w_accept),
    .i_gear_period (i_gear_period),
    .i_div_limit   (i_div_limit),
    .i_err_flag    (i_err_flag),
    .i_mu_lms      (i_mu_lms),
    .o_gear        (o_gear),
    .o_mu_lms      (o_mu_lms),
    .o_diverged    (w_diverged)
  );

  always_comb begin
    w_phase_nxt = r_phase;
    w_saved_nxt = r_saved;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_iter_nxt  = r_iter;
    w_fb_nxt    = r_fb;
    w_valid_nxt = r_wr_valid;
    w_data_nxt  = r_new_coeff;
    w_strobe    = 1'b0;
    w_to_lms    = 1'b0;

    case (r_phase)
      PH_IDLE: begin
        if (w_adv) begin
          w_phase_nxt = PH_STARTUP;
          w_cnt_nxt   = '0;
        end
      end
      PH_STARTUP: begin
        if (w_adv) begin
          if (w_cnt_done) begin
            w_phase_nxt = PH_CMA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + NB_CNT'(1);
          end
        end
      end
      PH_CMA, PH_LMS: begin
        if (i_freeze) begin
          w_phase_nxt = PH_HOLD;
          w_saved_nxt = r_phase;
        end else if (enable) begin
          if (r_div >= i_update_div) begin
            w_strobe  = 1'b1;
            w_div_nxt = '0;
          end else begin
            w_div_nxt = r_div + 8'd1;
          end
          if (r_phase == PH_CMA) begin
            if (w_cnt_done) begin
              w_phase_nxt = PH_LMS;
              w_cnt_nxt   = '0;
              w_to_lms    = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + NB_CNT'(1);
            end
          end else if (w_diverged) begin
            w_phase_nxt = PH_CMA;
            w_cnt_nxt   = '0;
            if (r_fb != 8'hFF) w_fb_nxt = r_fb + 8'd1;
          end
        end
      end
      PH_HOLD: begin
        if (!i_freeze) w_phase_nxt = r_saved;
      end
      default: w_phase_nxt = PH_IDLE;
    endcase

    if (w_adv && w_running && (r_iter != '1)) w_iter_nxt = r_iter + NB_CNT'(1);

    // A strobe only lands when the write slot is free or being freed this cycle.
    if (w_strobe && (!r_wr_valid || wr.wr_ready)) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = (r_phase == PH_LMS) ? i_lms_coeff : i_cma_coeff;
    end else if (w_accept) begin
      w_valid_nxt = 1'b0;
    end

    if (i_restart) begin
      w_phase_nxt = PH_STARTUP;
      w_cnt_nxt   = '0;
      w_div_nxt   = '0;
      w_iter_nxt  = '0;
      w_fb_nxt    = r_fb;
      w_valid_nxt = 1'b0;
      w_data_nxt  = r_new_coeff;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase     <= PH_IDLE;
      r_saved     <= PH_CMA;
      r_cnt       <= '0;
      r_div       <= '0;
      r_iter      <= '0;
      r_fb        <= '0;
      r_wr_valid  <= 1'b0;
      r_new_coeff <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_saved     <= w_saved_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_iter      <= w_iter_nxt;
      r_fb        <= w_fb_nxt;
      r_wr_valid  <= w_valid_nxt;
      r_new_coeff <= w_data_nxt;
    end
  end

  assign wr.new_coeff        = r_new_coeff;
  assign wr.wr_valid         = r_wr_valid;
  assign o_mu_cma            = (r_phase == PH_CMA) ? i_mu_cma : '0;
  assign o_phase             = r_phase;
  assign o_iteration_count   = r_iter;
  assign o_fallback_count    = r_fb;

endmodule
`default_nettype wire

// File: tb/tb_adaptation_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_adaptation_scheduler
// Desc   : Directed plus randomized check of adaptation_scheduler against a
//          cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_adaptation_scheduler;
  import adaptation_scheduler_pkg::*;

  localparam int FFE_LEN = 21;
  localparam int NB      = 8;
  localparam int CW      = FFE_LEN * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enable, restart, freeze, err_flag;
  logic [31:0]   startup_delay, cma_duration, gear_period;
  logic [7:0]    update_div;
  logic [15:0]   div_limit, mu_cma, mu_lms;
  logic [CW-1:0] coeff_flat, cma_coeff, lms_coeff;
  logic [15:0]   mu_cma_o, mu_lms_o;
  logic [2:0]    phase_o;
  logic [1:0]    gear_o;
  logic [31:0]   iter_o;
  logic [7:0]    fb_o;

  adaptation_scheduler_if #(.FFE_LEN(FFE_LEN), .NB(NB)) wr_if ();

  adaptation_scheduler #(.FFE_LEN(FFE_LEN), .NB(NB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .i_restart         (restart),
    .i_freeze          (freeze),
    .i_startup_delay   (startup_delay),
    .i_cma_duration    (cma_duration),
    .i_update_div      (update_div),
    .i_gear_period     (gear_period),
    .i_div_limit       (div_limit),
    .i_err_flag        (err_flag),
    .i_mu_cma          (mu_cma),
    .i_mu_lms          (mu_lms),
    .i_coeff_flat      (coeff_flat),
    .i_cma_coeff       (cma_coeff),
    .i_lms_coeff       (lms_coeff),
    .wr                (wr_if),
    .o_mu_cma          (mu_cma_o),
    .o_mu_lms          (mu_lms_o),
    .o_phase           (phase_o),
    .o_gear            (gear_o),
    .o_iteration_count (iter_o),
    .o_fallback_count  (fb_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase lengths as countdowns, gear as accepted-writes / period.
  int            m_phase, m_saved, m_left, m_tick, m_acc, m_err, m_fb;
  longint        m_iter;
  bit            m_valid;
  logic [CW-1:0] m_data;

  function automatic int len_of(input logic [31:0] x);
    return (x == 0) ? 1 : int'(x);
  endfunction

  function automatic int exp_gear();
    int g;
    if (gear_period == 0) return 0;
    g = m_acc / int'(gear_period);
    return (g > 3) ? 3 : g;
  endfunction

  function automatic logic [CW-1:0] rand_coeff();
    logic [CW-1:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[CW-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic bump_iter();
    if (m_iter < 64'hFFFF_FFFF) m_iter++;
  endtask

  task automatic model_step();
    bit accept, pending, strobe;
    int ph0;
    if (!rst_n) begin
      m_phase = 4; m_saved = 1; m_left = 0; m_tick = 0; m_acc = 0; m_err = 0;
      m_fb = 0; m_iter = 0; m_valid = 0; m_data = '0;
      return;
    end
    accept  = m_valid && wr_if.wr_ready;
    pending = m_valid && !wr_if.wr_ready;
    if (restart) begin
      m_phase = 0; m_left = len_of(startup_delay); m_tick = 0; m_acc = 0; m_err = 0;
      m_iter = 0; m_valid = 0;
      return;
    end
    strobe = 0;
    ph0 = m_phase;
    case (m_phase)
      4: if (enable && !freeze) begin m_phase = 0; m_left = len_of(startup_delay); end
      0: if (enable && !freeze) begin
        bump_iter();
        m_left--;
        if (m_left == 0) begin m_phase = 1; m_left = len_of(cma_duration); end
      end
      1, 2: if (freeze) begin
        m_saved = m_phase; m_phase = 3;
      end else if (enable) begin
        bump_iter();
        m_tick++;
        if (m_tick > int'(update_div)) begin strobe = 1; m_tick = 0; end
        if (m_phase == 1) begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_acc = 0; m_err = 0; end
        end else begin
          if (accept) m_acc++;
          m_err = err_flag ? m_err + 1 : 0;
          if (div_limit != 0 && m_err >= int'(div_limit)) begin
            m_phase = 1; m_left = len_of(cma_duration); m_acc = 0; m_err = 0;
            if (m_fb < 255) m_fb++;
          end
        end
      end
      3: if (!freeze) m_phase = m_saved;
      default: ;
    endcase
    if (strobe && !pending) begin
      m_valid = 1;
      m_data  = (ph0 == 2) ? lms_coeff : cma_coeff;
    end else if (accept) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    logic [15:0] e_cma, e_lms;
    int g, t;
    g = exp_gear();
    t = int'($signed(mu_lms));
    t = t >>> g;
    e_cma = (m_phase == 1) ? mu_cma : 16'h0;
    e_lms = (m_phase == 2) ? 16'(t) : 16'h0;
    check_eq("phase",     phase_o,         m_phase);
    check_eq("wr_valid",  wr_if.wr_valid,  m_valid);
    check_eq("new_coeff", wr_if.new_coeff, m_data);
    check_eq("mu_cma",    mu_cma_o,        e_cma);
    check_eq("mu_lms",    mu_lms_o,        e_lms);
    check_eq("gear",      gear_o,          g);
    check_eq("iteration", iter_o,          m_iter);
    check_eq("fallback",  fb_o,            m_fb);
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 unit after the rising edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    int n_ep, ep_len, errp;
    rst_n = 0; enable = 0; restart = 0; freeze = 0; err_flag = 0;
    startup_delay = 4; cma_duration = 10; update_div = 0; gear_period = 0; div_limit = 0;
    mu_cma = 16'h1234; mu_lms = 16'h4000;
    coeff_flat = rand_coeff(); cma_coeff = rand_coeff(); lms_coeff = rand_coeff();
    wr_if.wr_ready = 1;
    @(negedge clk);
    repeat (3) tick();
    check_eq("rst_phase", phase_o, 3'd4);
    check_eq("rst_valid", wr_if.wr_valid, 1'b0);
    rst_n = 1;

    // Timeline: 4 STARTUP cycles, 10 CMA cycles, then LMS with per-cycle commits.
    enable = 1;
    for (int k = 1; k <= 25; k++) begin
      cma_coeff = rand_coeff(); lms_coeff = rand_coeff();
      tick();
      if (k == 4)  check_eq("d1_startup_end", phase_o, 3'd0);
      if (k == 5)  check_eq("d1_cma_start",   phase_o, 3'd1);
      if (k == 6)  check_eq("d1_first_write", wr_if.wr_valid, 1'b1);
      if (k == 14) check_eq("d1_cma_end",     phase_o, 3'd1);
      if (k == 15) check_eq("d1_lms_start",   phase_o, 3'd2);
    end

    // Decimated commits with back-pressure.
    update_div = 3;
    for (int k = 0; k < 22; k++) begin
      wr_if.wr_ready = !(k >= 8 && k < 14);
      cma_coeff = rand_coeff(); lms_coeff = rand_coeff();
      tick();
    end
    wr_if.wr_ready = 1;

    // Gear shifting down to the last gear.
    update_div = 0; gear_period = 2; mu_lms = 16'h4000;
    startup_delay = 0; cma_duration = 0;
    restart = 1; tick(); restart = 0;
    repeat (15) tick();
    check_eq("d3_mu_floor", mu_lms_o, 16'h0800);
    check_eq("d3_gear_max", gear_o, 2'd3);

    // Divergence: four error cycles are tolerated, five fall back to CMA.
    div_limit = 5;
    err_flag = 1; repeat (4) tick();
    err_flag = 0; tick();
    check_eq("d4_no_fallback", phase_o, 3'd2);
    check_eq("d4_fb_zero", fb_o, 8'd0);
    err_flag = 1; repeat (5) tick();
    check_eq("d4_fallback_phase", phase_o, 3'd1);
    check_eq("d4_fallback_gear", gear_o, 2'd0);
    check_eq("d4_fallback_count", fb_o, 8'd1);
    err_flag = 0;

    // Freeze during CMA, then resume the remaining duration.
    cma_duration = 20;
    restart = 1; tick(); restart = 0;
    repeat (6) tick();
    freeze = 1; repeat (8) tick();
    check_eq("d5_hold", phase_o, 3'd3);
    freeze = 0; tick();
    check_eq("d5_resume", phase_o, 3'd1);
    repeat (25) tick();

    // Restart cancels a pending write; reset mid-LMS clears everything.
    wr_if.wr_ready = 0;
    repeat (2) tick();
    check_eq("d6_pending", wr_if.wr_valid, 1'b1);
    restart = 1; tick(); restart = 0;
    check_eq("d6_cancel", wr_if.wr_valid, 1'b0);
    check_eq("d6_phase", phase_o, 3'd0);
    check_eq("d6_iter", iter_o, 32'd0);
    wr_if.wr_ready = 1; cma_duration = 2;
    repeat (6) tick();
    rst_n = 0; tick();
    check_eq("d6_rst_phase", phase_o, 3'd4);
    check_eq("d6_rst_fb", fb_o, 8'd0);
    rst_n = 1;

    // Randomized episodes; configuration only changes across a restart or reset.
    n_ep = 12;
    for (int ep = 0; ep < n_ep; ep++) begin
      startup_delay = $urandom_range(0, 6);
      cma_duration  = $urandom_range(0, 15);
      update_div    = 8'($urandom_range(0, 3));
      gear_period   = $urandom_range(0, 3);
      div_limit     = 16'($urandom_range(0, 5));
      errp          = (ep % 3 == 0) ? 0 : ((ep % 3 == 1) ? 50 : 85);
      if ($urandom_range(0, 3) == 0) begin rst_n = 0; tick(); rst_n = 1; end
      else begin restart = 1; tick(); restart = 0; end
      ep_len = $urandom_range(150, 350);
      for (int k = 0; k < ep_len; k++) begin
        enable         = ($urandom_range(0, 7) != 0);
        freeze         = freeze ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
        restart        = ($urandom_range(0, 199) == 0);
        err_flag       = ($urandom_range(0, 99) < errp);
        wr_if.wr_ready = ($urandom_range(0, 3) != 0);
        mu_cma         = 16'($urandom);
        mu_lms         = 16'($urandom);
        cma_coeff      = rand_coeff();
        lms_coeff      = rand_coeff();
        coeff_flat     = rand_coeff();
        tick();
      end
      restart = 0; freeze = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
